// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave bus-cycle controller: strobe synchronisers, fixed-priority target
// arbitration and the IDLE/START/DATA/END cycle FSM with ack, fixed-wait and watchdog completion.
module z2_cycle_ctrl #(
  parameter int                NUM_CH      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] ACK_MODE    = NUM_CH'(1),
  parameter int                WAIT_CYCLES = 3,
  parameter int                TIMEOUT     = 63
) (
  input  logic              MEMCLK,
  input  logic              RESET_n,
  input  logic              AS_n,
  input  logic              UDS_n,
  input  logic              LDS_n,
  input  logic              RW,
  input  logic [NUM_CH-1:0] sel,
  input  logic [NUM_CH-1:0] ack,
  output logic              as_n_s,
  output logic              uds_n_s,
  output logic              lds_n_s,
  output logic              rw_s,
  output logic [1:0]        z2_state,
  output logic [NUM_CH-1:0] cyc_sel,
  output logic              data_phase,
  output logic              dtack_req,
  output logic              berr_req,
  output logic [7:0]        timeout_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_END   = 2'd3
  } state_t;

  localparam logic [7:0] L_WAIT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] L_TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] L_TO_MAX    = 8'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_as_sync;
  logic [SYNC_STAGES-1:0] r_uds_sync;
  logic [SYNC_STAGES-1:0] r_lds_sync;
  logic [SYNC_STAGES-1:0] r_rw_sync;

  state_t            r_state;
  logic [NUM_CH-1:0] r_cyc_sel;
  logic [7:0]        r_cnt;
  logic              r_dtack;
  logic              r_berr;
  logic [7:0]        r_timeout_cnt;

  logic              w_as_n_s;
  logic              w_ds_active;
  logic [NUM_CH-1:0] w_grant;
  logic              w_ack_done;
  logic              w_wait_done;
  logic              w_timeout;

  // All strobes idle high out of reset so the FSM never sees a phantom cycle start.
  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_as_sync  <= '1;
      r_uds_sync <= '1;
      r_lds_sync <= '1;
      r_rw_sync  <= '1;
    end else begin
      r_as_sync  <= {r_as_sync[SYNC_STAGES-2:0],  AS_n};
      r_uds_sync <= {r_uds_sync[SYNC_STAGES-2:0], UDS_n};
      r_lds_sync <= {r_lds_sync[SYNC_STAGES-2:0], LDS_n};
      r_rw_sync  <= {r_rw_sync[SYNC_STAGES-2:0],  RW};
    end
  end

  assign w_as_n_s    = r_as_sync[SYNC_STAGES-1];
  assign w_ds_active = !r_uds_sync[SYNC_STAGES-1] || !r_lds_sync[SYNC_STAGES-1];

  // Isolate the lowest set bit of sel: fixed priority, channel 0 wins.
  assign w_grant = sel & (~sel + NUM_CH'(1));

  // Target handshake: a target sees its cyc_sel bit with data_phase high and may
  // answer with a one-cycle-or-longer ack; ack only counts for the granted
  // handshake-mode channel while in DATA. The cycle then ends with exactly one of
  // dtack_req/berr_req held high until the master drops AS.
  assign w_ack_done  = |(r_cyc_sel & ACK_MODE & ack);
  assign w_wait_done = (|(r_cyc_sel & ~ACK_MODE)) && (r_cnt == L_WAIT_LAST);
  assign w_timeout   = (r_cnt == L_TO_LAST);

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state       <= S_IDLE;
      r_cyc_sel     <= '0;
      r_cnt         <= '0;
      r_dtack       <= 1'b0;
      r_berr        <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_as_n_s && (|sel)) begin
            r_state   <= S_START;
            r_cyc_sel <= w_grant;
            r_cnt     <= '0;
          end
        end
        S_START: begin
          if (w_as_n_s) begin
            r_state   <= S_IDLE;
            r_cyc_sel <= '0;
          end else if (w_ds_active) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_as_n_s) begin
            r_state   <= S_IDLE;
            r_cyc_sel <= '0;
            r_cnt     <= '0;
          end else begin
            if (r_cnt != L_TO_MAX) begin
              r_cnt <= r_cnt + 8'd1;
            end
            if (w_ack_done) begin
              r_state <= S_END;
              r_dtack <= 1'b1;
            end else if (w_wait_done) begin
              r_state <= S_END;
              r_dtack <= 1'b1;
            end else if (w_timeout) begin
              r_state <= S_END;
              r_berr  <= 1'b1;
              if (r_timeout_cnt != 8'hFF) begin
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
              end
            end
          end
        end
        S_END: begin
          if (w_as_n_s) begin
            r_state   <= S_IDLE;
            r_cyc_sel <= '0;
            r_dtack   <= 1'b0;
            r_berr    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign as_n_s      = w_as_n_s;
  assign uds_n_s     = r_uds_sync[SYNC_STAGES-1];
  assign lds_n_s     = r_lds_sync[SYNC_STAGES-1];
  assign rw_s        = r_rw_sync[SYNC_STAGES-1];
  assign z2_state    = r_state;
  assign cyc_sel     = r_cyc_sel;
  assign data_phase  = (r_state == S_DATA);
  assign dtack_req   = r_dtack;
  assign berr_req    = r_berr;
  assign timeout_cnt = r_timeout_cnt;

  a_no_dtack_and_berr: assert property (@(posedge MEMCLK) disable iff (!RESET_n)
    !(r_dtack && r_berr));
  a_grant_onehot0: assert property (@(posedge MEMCLK) disable iff (!RESET_n)
    $onehot0(r_cyc_sel));

endmodule
